reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the data path width, matching RegFile W.
REQ-002 The block SHALL have parameter A, default 2, meaning the register address width, with 2**A registers.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports Clk and Reset.
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous reset, active-low.
REQ-004 Requester 0 (ALU writeback) SHALL have these ports:
- Req0  input  1  write request.
- Addr0  input  A  target register.
- Data0  input  W  write data.
- Ack0  output  1  request accepted this cycle.
REQ-005 Requester 1 (load return) SHALL have these ports:
- Req1  input  1  write request.
- Addr1  input  A  target register.
- Data1  input  W  write data.
- Lock1  input  1  hold the grant for back-to-back writes.
- Ack1  output  1  request accepted this cycle.
REQ-006 The RegFile write side SHALL have these ports:
- WriteEn  output  1  registered write strobe.
- Waddr  output  A  registered write address.
- DataIn  output  W  registered write data.
REQ-007 The hazard/bypass side SHALL have these ports:
- RaddrA  input  A  read address A.
- RaddrB  input  A  read address B.
- HitA  output  1  WriteEn is set and Waddr equals RaddrA.
- HitB  output  1  WriteEn is set and Waddr equals RaddrB.
- FwdData  output  W  equals DataIn.
- Owner  output  1  requester that owns the current WriteEn.

Function
REQ-008 Arbitration SHALL be combinational each cycle, with at most one of Ack0 and Ack1 high.
REQ-009 A request SHALL be accepted only on a cycle where Req and Ack are both high. A requester not acked SHALL hold Req, Addr and Data stable until it is acked.
REQ-010 With only one Req high, that requester SHALL be acked.
REQ-011 With both Req high, the requester other than the internal LastGnt bit SHALL be acked (round-robin).
REQ-012 LastGnt SHALL update to the acked requester on every accepting cycle and SHALL hold otherwise.
REQ-013 Lock state SHALL override round-robin:
- Locked sets when Ack1 and Lock1 are both high.
- While Locked and Req1 are high, Ack1 SHALL be forced high and Ack0 low.
- Locked clears on any cycle where Lock1 or Req1 is low.
REQ-014 Locked SHALL last at most 4 consecutive grants. On the 4th locked grant, Locked SHALL clear and LastGnt SHALL equal 1, so a pending Req0 wins the next cycle.
REQ-015 Write-side outputs SHALL have 1-cycle latency:
- Edge after an accept: WriteEn=1, and Waddr, DataIn and Owner take the accepted request's values.
- Edge after a cycle with no accept: WriteEn=0, and Waddr, DataIn and Owner hold their values.
REQ-016 Back-to-back accepts SHALL produce WriteEn high on consecutive cycles, giving one write per cycle at full throughput.
REQ-017 Same-address requests from both ports on one cycle SHALL be serialized in ack order, so the later-acked data is the final register value.
REQ-018 HitA, HitB and FwdData SHALL be combinational from the registered outputs and RaddrA/RaddrB. They SHALL carry no dependency on Req0/Req1 in the same cycle.
REQ-019 Width rule: no arithmetic is performed. The lock counter SHALL be 2 bits and saturate its behaviour at the 4th grant (REQ-014).

Reset
REQ-020 While Reset is low, outputs SHALL be held at:
- WriteEn=0, Waddr=0, DataIn=0, Owner=0, Ack0=0, Ack1=0.
- HitA=0, HitB=0, FwdData=0.
REQ-021 While Reset is low, LastGnt SHALL be 1 (port 0 favoured first), Locked=0 and the lock counter=0.
REQ-022 Reset assertion mid-operation SHALL drop WriteEn without waiting for a clock edge. Any accepted-but-unissued write SHALL be discarded.
REQ-023 On the first edge after Reset deasserts, normal arbitration SHALL apply. Ack SHALL be low while Reset is low.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, then Req0 alone with Addr0=2, Data0=8'hA5 -> Ack0=1 in cycle 0; cycle 1: WriteEn=1, Waddr=2, DataIn=A5, Owner=0.
- Req0 and Req1 both held high for 4 cycles -> acks alternate 0,1,0,1; WriteEn high for 4 consecutive cycles.
- Req1 with Lock1 held high for 6 cycles, Req0 also high -> Ack1 for 4 cycles, then Ack0, then Ack1.
- Both ports target Addr=3 (Data0=11, Data1=22) with LastGnt=1 -> writes issued 11 then 22, final R3=22.
- Registered write to Waddr=1, RaddrA=1, RaddrB=0 -> HitA=1, HitB=0, FwdData equals the issued data.
- Reset pulsed low mid-cycle while WriteEn=1 -> WriteEn=0 immediately; after release, Req0 wins the first contention.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Bundle of requester, RegFile write-side and bypass signals around reg_write_arbiter.
// The arbiter is the slave; requesters, RegFile and hazard logic together form the master.
interface reg_write_arbiter_if #(
    parameter int W = 8,
    parameter int A = 2
);
    logic         Req0;
    logic [A-1:0] Addr0;
    logic [W-1:0] Data0;
    logic         Ack0;

    logic         Req1;
    logic [A-1:0] Addr1;
    logic [W-1:0] Data1;
    logic         Lock1;
    logic         Ack1;

    logic         WriteEn;
    logic [A-1:0] Waddr;
    logic [W-1:0] DataIn;

    logic [A-1:0] RaddrA;
    logic [A-1:0] RaddrB;
    logic         HitA;
    logic         HitB;
    logic [W-1:0] FwdData;
    logic         Owner;

    modport slave (
        input  Req0, Addr0, Data0, Req1, Addr1, Data1, Lock1, RaddrA, RaddrB,
        output Ack0, Ack1, WriteEn, Waddr, DataIn, HitA, HitB, FwdData, Owner
    );

    modport master (
        output Req0, Addr0, Data0, Req1, Addr1, Data1, Lock1, RaddrA, RaddrB,
        input  Ack0, Ack1, WriteEn, Waddr, DataIn, HitA, HitB, FwdData, Owner
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter for the RegFile write port, with a bounded
// lock for back-to-back load returns and a registered write side plus bypass hits.
module reg_write_arbiter #(
    parameter int W = 8,
    parameter int A = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    reg_write_arbiter_if.slave  bus
);

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lock_state_t;

    lock_state_t  state, state_nxt;
    logic [1:0]   lock_cnt, lock_cnt_nxt;
    logic         last_gnt, last_gnt_nxt;
    logic         ack0, ack1, accept;

    logic         write_en;
    logic [A-1:0] waddr;
    logic [W-1:0] data_in;
    logic         owner;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= LOCK_OPEN;
            lock_cnt <= 2'd0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        ack0         = 1'b0;
        ack1         = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        last_gnt_nxt = last_gnt;

        if (Reset) begin
            if (state == LOCK_HELD && bus.Req1) begin
                ack1 = 1'b1;
            end else if (bus.Req0 && bus.Req1) begin
                ack0 = last_gnt;
                ack1 = !last_gnt;
            end else begin
                ack0 = bus.Req0;
                ack1 = bus.Req1;
            end
        end

        if (ack0) last_gnt_nxt = 1'b0;
        if (ack1) last_gnt_nxt = 1'b1;

        // The lock spans at most four grants, counting the grant that takes it.
        if (!bus.Lock1 || !bus.Req1) begin
            state_nxt    = LOCK_OPEN;
            lock_cnt_nxt = 2'd0;
        end else if (ack1) begin
            if (state == LOCK_OPEN) begin
                state_nxt    = LOCK_HELD;
                lock_cnt_nxt = 2'd1;
            end else if (lock_cnt == 2'd3) begin
                state_nxt    = LOCK_OPEN;
                lock_cnt_nxt = 2'd0;
            end else begin
                lock_cnt_nxt = lock_cnt + 2'd1;
            end
        end
    end

    assign accept = ack0 || ack1;

    // Address/data/owner hold across idle cycles; only the strobe drops.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            write_en <= 1'b0;
            waddr    <= '0;
            data_in  <= '0;
            owner    <= 1'b0;
        end else begin
            write_en <= accept;
            if (accept) begin
                waddr   <= ack1 ? bus.Addr1 : bus.Addr0;
                data_in <= ack1 ? bus.Data1 : bus.Data0;
                owner   <= ack1;
            end
        end
    end

    assign bus.Ack0    = ack0;
    assign bus.Ack1    = ack1;
    assign bus.WriteEn = write_en;
    assign bus.Waddr   = waddr;
    assign bus.DataIn  = data_in;
    assign bus.Owner   = owner;

    // Bypass uses only registered state, never this cycle's requests.
    assign bus.HitA    = write_en && (waddr == bus.RaddrA);
    assign bus.HitB    = write_en && (waddr == bus.RaddrB);
    assign bus.FwdData = data_in;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, round-robin, lock limit,
// same-address serialization, bypass hits and asynchronous reset mid-write.
module tb_reg_write_arbiter;

    localparam int W = 8;
    localparam int A = 2;

    logic Clk;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] rf [4];
    logic [5:0]   lock_pat;

    reg_write_arbiter_if #(.W(W), .A(A)) bus ();

    reg_write_arbiter #(.W(W), .A(A)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // RegFile model downstream of the write port.
    always @(posedge Clk) begin
        if (bus.WriteEn) rf[bus.Waddr] <= bus.DataIn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset      = 1'b0;
        bus.Req0   = 1'b1;
        bus.Addr0  = '0;
        bus.Data0  = '0;
        bus.Req1   = 1'b0;
        bus.Addr1  = '0;
        bus.Data1  = '0;
        bus.Lock1  = 1'b0;
        bus.RaddrA = '0;
        bus.RaddrB = '0;
        lock_pat   = 6'b101111;

        // Reset state, with a request pending to show acks are gated
        repeat (2) @(posedge Clk);
        #2;
        check("rst_writeen", bus.WriteEn, 0);
        check("rst_waddr",   bus.Waddr,   0);
        check("rst_datain",  bus.DataIn,  0);
        check("rst_owner",   bus.Owner,   0);
        check("rst_ack0",    bus.Ack0,    0);
        check("rst_ack1",    bus.Ack1,    0);
        check("rst_hita",    bus.HitA,    0);
        check("rst_hitb",    bus.HitB,    0);
        check("rst_fwd",     bus.FwdData, 0);
        @(negedge Clk);
        Reset    = 1'b1;
        bus.Req0 = 1'b0;

        // Single write from port 0
        step();
        bus.Req0 = 1'b1; bus.Addr0 = 2'd2; bus.Data0 = 8'hA5;
        #1;
        check("s1_ack0", bus.Ack0, 1);
        check("s1_ack1", bus.Ack1, 0);
        step();
        bus.Req0 = 1'b0;
        check("s1_writeen", bus.WriteEn, 1);
        check("s1_waddr",   bus.Waddr,   2);
        check("s1_datain",  bus.DataIn,  8'hA5);
        check("s1_owner",   bus.Owner,   0);
        step();
        check("idle_writeen", bus.WriteEn, 0);
        check("idle_waddr",   bus.Waddr,   2);
        check("idle_datain",  bus.DataIn,  8'hA5);

        // Port 1 alone, leaving LastGnt = 1
        bus.Req1 = 1'b1; bus.Addr1 = 2'd1; bus.Data1 = 8'h1B;
        #1;
        check("solo1_ack1", bus.Ack1, 1);
        step();
        check("solo1_owner", bus.Owner, 1);

        // Round-robin contention for 4 cycles
        bus.Req0 = 1'b1; bus.Addr0 = 2'd0; bus.Data0 = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_ack1_%0d", i), bus.Ack1, i % 2);
            check($sformatf("rr_ack0_%0d", i), bus.Ack0, 1 - (i % 2));
            step();
            check($sformatf("rr_writeen_%0d", i), bus.WriteEn, 1);
            check($sformatf("rr_owner_%0d", i), bus.Owner, i % 2);
            check($sformatf("rr_datain_%0d", i), bus.DataIn, (i % 2) ? 8'h1B : 8'h0A);
        end
        bus.Req1 = 1'b0;

        // Port 0 alone so LastGnt = 0, then locked contention
        #1;
        check("pre_lock_ack0", bus.Ack0, 1);
        step();
        bus.Req1  = 1'b1;
        bus.Lock1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("lock_ack1_%0d", i), bus.Ack1, lock_pat[i]);
            check($sformatf("lock_ack0_%0d", i), bus.Ack0, !lock_pat[i]);
            step();
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.Lock1 = 1'b0;
        #1;
        check("unlock_ack0", bus.Ack0, 0);
        check("unlock_ack1", bus.Ack1, 0);
        step();

        // Same address from both ports with LastGnt = 1
        bus.Req0 = 1'b1; bus.Addr0 = 2'd3; bus.Data0 = 8'h11;
        bus.Req1 = 1'b1; bus.Addr1 = 2'd3; bus.Data1 = 8'h22;
        #1;
        check("same_ack0", bus.Ack0, 1);
        step();
        check("same_w1_data", bus.DataIn, 8'h11);
        check("same_w1_addr", bus.Waddr,  3);
        bus.Req0 = 1'b0;
        #1;
        check("same_ack1", bus.Ack1, 1);
        step();
        check("same_w2_data",  bus.DataIn, 8'h22);
        check("same_w2_owner", bus.Owner,  1);
        bus.Req1 = 1'b0;
        step();
        check("same_r3", rf[3], 8'h22);

        // Bypass hits from the registered write
        bus.Req0 = 1'b1; bus.Addr0 = 2'd1; bus.Data0 = 8'h3C;
        bus.RaddrA = 2'd1; bus.RaddrB = 2'd0;
        #1;
        check("hit_pre_hita", bus.HitA, 0);
        step();
        bus.Req0 = 1'b0;
        check("hit_hita", bus.HitA,    1);
        check("hit_hitb", bus.HitB,    0);
        check("hit_fwd",  bus.FwdData, 8'h3C);
        bus.RaddrB = 2'd1;
        #1;
        check("hit_hitb_match", bus.HitB, 1);
        step();
        check("hit_hita_idle", bus.HitA, 0);

        // Reset mid-cycle while a write is issued and another is being accepted
        bus.Req0 = 1'b1; bus.Addr0 = 2'd2; bus.Data0 = 8'h5A;
        #1;
        check("mid_ack0", bus.Ack0, 1);
        step();
        check("mid_writeen", bus.WriteEn, 1);
        bus.Data0 = 8'h66;
        #2;
        Reset = 1'b0;
        #1;
        check("mid_rst_writeen", bus.WriteEn, 0);
        check("mid_rst_datain",  bus.DataIn,  0);
        check("mid_rst_ack0",    bus.Ack0,    0);
        step();
        check("mid_rst_discard", bus.WriteEn, 0);
        @(negedge Clk);
        Reset    = 1'b1;
        bus.Req1 = 1'b1; bus.Addr1 = 2'd0; bus.Data1 = 8'h77;
        #1;
        check("post_rst_ack0", bus.Ack0, 1);
        check("post_rst_ack1", bus.Ack1, 0);
        step();
        check("post_rst_writeen", bus.WriteEn, 1);
        check("post_rst_data",    bus.DataIn,  8'h66);
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
